ripple_count_monitor: RTL and testbench

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

---
 rtl/ripple_count_monitor.sv | 159 +++++++++++++++
 tb/tb_ripple_count_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// Glitch-filtering monitor for an external 4-bit ripple counter: synchronizes, debounces and tracks 15->0 wraps.
// Optional RCM_OVERRUN_EN: protect an unread snapshot and flag the overrun instead of overwriting it.
module ripple_count_monitor #(
    parameter int unsigned STABLE_N = 2
) (
    input  logic        CLOCK,
    input  logic        CLEAR,
    input  logic [3:0]  Q_IN,
    input  logic        RD,
    output logic [3:0]  COUNT,
    output logic [7:0]  WRAP_CNT,
    output logic        TC,
    output logic        VALID,
    output logic [11:0] SNAP,
    output logic        OVR
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WRAP_W = 8;
    localparam int unsigned SNAP_W = WRAP_W + CNT_W;
    localparam int unsigned RUN_W  = 3;

    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(7);
    localparam logic [RUN_W-1:0] STABLE_THR = RUN_W'(STABLE_N);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CNT_W-1:0]  s1_q, s2_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              tc_q, tc_d;
    logic              valid_q, valid_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [WRAP_W-1:0] wrap_inc_c;
    logic              accept_c;
    logic              wrap_c;

    // Run length of s2 holding its value; saturates so long stable periods keep qualifying.
    always_comb begin
        run_d = run_q;
        if (s1_q != s2_q) begin
            run_d = RUN_ONE;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_ONE;
        end
    end

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            s1_q  <= '0;
            s2_q  <= '0;
            run_q <= '0;
        end else begin
            s1_q  <= Q_IN;
            s2_q  <= s1_q;
            run_q <= run_d;
        end
    end

    assign accept_c   = (run_q >= STABLE_THR) && (s2_q != count_q);
    assign wrap_c     = accept_c && (state_q == ST_RUN) && (count_q == CNT_TOP) && (s2_q == CNT_ZERO);
    assign wrap_inc_c = wrap_q + WRAP_W'(1);

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // The first accepted value only seeds COUNT; wrap tracking starts from there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (accept_c) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = wrap_q;
        tc_d    = 1'b0;
        valid_d = valid_q;
        snap_d  = snap_q;
        if (accept_c) begin
            count_d = s2_q;
        end
        if (wrap_c) begin
            wrap_d  = wrap_inc_c;
            tc_d    = 1'b1;
            valid_d = 1'b1;
`ifdef RCM_OVERRUN_EN
            if (!valid_q || RD) begin
                snap_d = {wrap_inc_c, CNT_ZERO};
            end
`else
            snap_d = {wrap_inc_c, CNT_ZERO};
`endif
        end else if (RD && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            count_q <= '0;
            wrap_q  <= '0;
            tc_q    <= 1'b0;
            valid_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            tc_q    <= tc_d;
            valid_q <= valid_d;
            snap_q  <= snap_d;
        end
    end

`ifdef RCM_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Sticky: a wrap landing on an unread, unacknowledged snapshot.
    always_comb begin
        ovr_d = ovr_q;
        if (wrap_c && valid_q && !RD) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign OVR = ovr_q;
`else
    assign OVR = 1'b0;
`endif

    assign COUNT    = count_q;
    assign WRAP_CNT = wrap_q;
    assign TC       = tc_q;
    assign VALID    = valid_q;
    assign SNAP     = snap_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor (default STABLE_N=2); expectations follow RCM_OVERRUN_EN if defined.
module tb_ripple_count_monitor;

    logic        CLOCK;
    logic        CLEAR;
    logic [3:0]  Q_IN;
    logic        RD;
    logic [3:0]  COUNT;
    logic [7:0]  WRAP_CNT;
    logic        TC;
    logic        VALID;
    logic [11:0] SNAP;
    logic        OVR;

    int checks   = 0;
    int failures = 0;
    int tc_seen  = 0;
    int tc_mark;
    logic [3:0] prev;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef RCM_OVERRUN_EN
    localparam logic [11:0] SNAP_TWO_WRAPS = 12'h010;
    localparam logic        OVR_TWO_WRAPS  = 1'b1;
`else
    localparam logic [11:0] SNAP_TWO_WRAPS = 12'h020;
    localparam logic        OVR_TWO_WRAPS  = 1'b0;
`endif

    ripple_count_monitor #(.STABLE_N(2)) dut (
        .CLOCK    (CLOCK),
        .CLEAR    (CLEAR),
        .Q_IN     (Q_IN),
        .RD       (RD),
        .COUNT    (COUNT),
        .WRAP_CNT (WRAP_CNT),
        .TC       (TC),
        .VALID    (VALID),
        .SNAP     (SNAP),
        .OVR      (OVR)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) if (TC === 1'b1) tc_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    // Drive v and check the 3-edge acceptance latency; optionally assert RD on the accepting edge.
    task automatic step(input logic [3:0] v, input logic [3:0] old, input logic exp_tc, input logic rd_at_accept);
        Q_IN = v;
        cyc(3);
        check("lat_hold", 32'(COUNT), 32'(old));
        RD = rd_at_accept;
        cyc(1);
        RD = 1'b0;
        check("lat_update", 32'(COUNT), 32'(v));
        check("tc_at_accept", 32'(TC), 32'(exp_tc));
        cyc(16);
    endtask

    task automatic clear_pulse();
        CLEAR = 1'b1;
        #2;
        CLEAR = 1'b0;
    endtask

    initial begin
        CLEAR = 1'b1;
        Q_IN  = 4'h3;
        RD    = 1'b0;

        // Reset state, then first acceptance from INIT
        #20;
        check("rst_count", 32'(COUNT), 32'h0);
        check("rst_wrap", 32'(WRAP_CNT), 32'h0);
        check("rst_tc", 32'(TC), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_snap", 32'(SNAP), 32'h0);
        check("rst_ovr", 32'(OVR), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(ST_INIT));
        #14;
        CLEAR = 1'b0;
        cyc(3);
        check("init_lat_hold", 32'(COUNT), 32'h0);
        cyc(1);
        check("init_count", 32'(COUNT), 32'h3);
        check("init_state", 32'(dut.state_q), 32'(ST_RUN));
        check("init_no_tc", 32'(tc_seen), 32'd0);
        check("init_wrap", 32'(WRAP_CNT), 32'h0);
        cyc(2);

        // Full count sweep ending in one wrap
        prev = 4'h3;
        for (int v = 0; v < 16; v++) begin
            step(4'(v), prev, 1'b0, 1'b0);
            prev = 4'(v);
        end
        step(4'h0, 4'hF, 1'b1, 1'b0);
        check("sweep_tc_count", 32'(tc_seen), 32'd1);
        check("sweep_wrap", 32'(WRAP_CNT), 32'h1);
        check("sweep_snap", 32'(SNAP), 32'h010);
        check("sweep_valid", 32'(VALID), 32'h1);
        check("sweep_ovr", 32'(OVR), 32'h0);

        // Single-cycle glitch is filtered
        step(4'h7, 4'h0, 1'b0, 1'b0);
        tc_mark = tc_seen;
        Q_IN = 4'h8;
        cyc(1);
        Q_IN = 4'h7;
        cyc(10);
        check("glitch_count", 32'(COUNT), 32'h7);
        check("glitch_no_tc", 32'(tc_seen), 32'(tc_mark));

        // Two wraps without a read
        clear_pulse();
        check("clr2_count", 32'(COUNT), 32'h0);
        check("clr2_state", 32'(dut.state_q), 32'(ST_INIT));
        step(4'hF, 4'h0, 1'b0, 1'b0);
        check("ovr_init_wrap", 32'(WRAP_CNT), 32'h0);
        check("ovr_init_valid", 32'(VALID), 32'h0);
        step(4'h0, 4'hF, 1'b1, 1'b0);
        check("ovr_first_snap", 32'(SNAP), 32'h010);
        step(4'hF, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 1'b0);
        check("ovr_wrap", 32'(WRAP_CNT), 32'h2);
        check("ovr_snap", 32'(SNAP), 32'(SNAP_TWO_WRAPS));
        check("ovr_flag", 32'(OVR), 32'(OVR_TWO_WRAPS));
        check("ovr_valid", 32'(VALID), 32'h1);

        // Wrap coincident with a read, then plain reads
        clear_pulse();
        check("clr3_ovr", 32'(OVR), 32'h0);
        step(4'hF, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 1'b0);
        step(4'hF, 4'h0, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b1, 1'b1);
        check("rdwrap_snap", 32'(SNAP), 32'h020);
        check("rdwrap_valid", 32'(VALID), 32'h1);
        check("rdwrap_ovr", 32'(OVR), 32'h0);
        RD = 1'b1;
        cyc(1);
        RD = 1'b0;
        check("rd_clears_valid", 32'(VALID), 32'h0);
        check("rd_keeps_snap", 32'(SNAP), 32'h020);
        RD = 1'b1;
        cyc(1);
        RD = 1'b0;
        check("rd_idle_valid", 32'(VALID), 32'h0);

        // Asynchronous clear mid-run
        clear_pulse();
        step(4'hF, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'h0, 4'hF, 1'b1, 1'b0);
            if (i < 4) step(4'hF, 4'h0, 1'b0, 1'b0);
        end
        step(4'h9, 4'h0, 1'b0, 1'b0);
        check("pre_clr_count", 32'(COUNT), 32'h9);
        check("pre_clr_wrap", 32'(WRAP_CNT), 32'h5);
        #3;
        CLEAR = 1'b1;
        #1;
        check("aclr_count", 32'(COUNT), 32'h0);
        check("aclr_wrap", 32'(WRAP_CNT), 32'h0);
        check("aclr_valid", 32'(VALID), 32'h0);
        check("aclr_snap", 32'(SNAP), 32'h0);
        check("aclr_ovr", 32'(OVR), 32'h0);
        check("aclr_tc", 32'(TC), 32'h0);
        check("aclr_state", 32'(dut.state_q), 32'(ST_INIT));
        #2;
        CLEAR = 1'b0;
        tc_mark = tc_seen;
        cyc(6);
        check("post_clr_count", 32'(COUNT), 32'h9);
        check("post_clr_wrap", 32'(WRAP_CNT), 32'h0);
        check("post_clr_no_tc", 32'(tc_seen), 32'(tc_mark));
        check("post_clr_state", 32'(dut.state_q), 32'(ST_RUN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
